// File: rtl/s444_bist_tester.sv
// BIST stimulus generator and 16-bit MISR response compactor for one s444 instance.
// Optional golden-signature comparator is compiled in with `define BIST_GOLDEN_CMP_EN.
module s444_bist_tester #(
   parameter int unsigned PAT_COUNT   = 255,
   parameter int unsigned INIT_CYCLES = 4,
   parameter logic [7:0]  LFSR_SEED   = 8'h01,
   parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
   input  logic        CK,
   input  logic        RST,
   input  logic        START,
   input  logic        ABORT,
   input  logic [5:0]  RESP,
   output logic [2:0]  PAT,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] SIGNATURE,
   output logic        PASS
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [7:0]  SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [7:0]  INIT_LAST = 8'(INIT_CYCLES - 1);
   localparam logic [15:0] PAT_LAST  = 16'(PAT_COUNT - 1);

   logic [2:0]  state_q, state_d;
   logic [7:0]  init_cnt_q, init_cnt_d;
   logic [15:0] pat_cnt_q, pat_cnt_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [15:0] misr_q, misr_d;
   logic        cap_en_q, cap_en_d;
   logic [2:0]  pat_q, pat_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;

   logic        busy_state;
   logic        abort_now;
   logic [7:0]  lfsr_step;
   logic [15:0] misr_step;

   assign busy_state = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_FLUSH);
   assign abort_now  = ABORT && busy_state;
   assign lfsr_step  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign misr_step  = ({misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000))
                       ^ {10'b0, RESP};

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      pat_cnt_d  = pat_cnt_q;
      lfsr_d     = lfsr_q;
      misr_d     = misr_q;
      pass_d     = 1'b0;

      // An aborting edge leaves the partial signature untouched
      if (cap_en_q && !abort_now) begin
         misr_d = misr_step;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_d    = S_INIT;
               lfsr_d     = SEED_EFF;
               misr_d     = '0;
               init_cnt_d = '0;
               pat_cnt_d  = '0;
            end
         end
         S_INIT: begin
            if (init_cnt_q == INIT_LAST) state_d = S_RUN;
            else                         init_cnt_d = init_cnt_q + 8'd1;
         end
         S_RUN: begin
            if (pat_cnt_q == PAT_LAST) state_d = S_FLUSH;
            else                       pat_cnt_d = pat_cnt_q + 16'd1;
         end
         S_FLUSH: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      if (abort_now) begin
         state_d = S_IDLE;
      end

      cap_en_d = (state_q == S_RUN) && !abort_now;

      // Each edge that drives a RUN pattern consumes the current LFSR value
      if (state_d == S_RUN) begin
         lfsr_d = lfsr_step;
      end

      case (state_d)
         S_INIT:  pat_d = 3'b001;
         S_RUN:   pat_d = lfsr_q[2:0];
         default: pat_d = 3'b000;
      endcase

      busy_d = (state_d == S_INIT) || (state_d == S_RUN) || (state_d == S_FLUSH);
      done_d = (state_d == S_DONE);

`ifdef BIST_GOLDEN_CMP_EN
      if (state_d == S_DONE) begin
         pass_d = (state_q == S_DONE) ? pass_q : (misr_d == GOLDEN_SIG);
      end
`endif
   end

`ifndef BIST_GOLDEN_CMP_EN
   logic unused_golden;
   assign unused_golden = ^GOLDEN_SIG ^ pass_q;
`endif

   always_ff @(posedge CK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         init_cnt_q <= '0;
         pat_cnt_q  <= '0;
         lfsr_q     <= SEED_EFF;
         misr_q     <= '0;
         cap_en_q   <= 1'b0;
         pat_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         pat_cnt_q  <= pat_cnt_d;
         lfsr_q     <= lfsr_d;
         misr_q     <= misr_d;
         cap_en_q   <= cap_en_d;
         pat_q      <= pat_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   assign PAT       = pat_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign SIGNATURE = misr_q;
`ifdef BIST_GOLDEN_CMP_EN
   assign PASS      = pass_q;
`else
   assign PASS      = 1'b0;
`endif

endmodule
